// File: rtl/rs_ctrl_pkg.sv
// Shared types and constants for the return-stack request scheduler.
// Holds the stack entry geometry, the per-thread depth counter width and the
// queued request record carried through the per-thread request FIFOs.
package rs_ctrl_pkg;

    localparam int RS_DATA_W = 67;
    localparam int RS_LNK_W  = 5;
    localparam int RS_DEPTH  = 16;

    // Depth counter must represent 0..RS_DEPTH inclusive.
    localparam int DEPTH_W = $clog2(RS_DEPTH + 1);

    typedef struct packed {
        logic                 pop;
        logic [RS_DATA_W-1:0] data;
        logic [RS_LNK_W-1:0]  lnk;
        logic                 trace;
    } rs_req_t;

endpackage

// File: rtl/ret_stack_ctrl_if.sv
// Bundle between branch prediction, the scheduler and the return stack.
// master: request/exception source and stack model side; slave: the scheduler.
// Carries per-thread requests, the stack strobes, pop responses and depth.
interface ret_stack_ctrl_if;
    import rs_ctrl_pkg::*;

    // request side, indexed by thread
    logic [1:0]                 req_vld;
    logic [1:0]                 req_pop;
    logic [1:0][RS_DATA_W-1:0]  req_data;
    logic [1:0][RS_LNK_W-1:0]   req_lnk;
    logic [1:0]                 req_trace;
    logic [1:0]                 req_rdy;

    // exception / redirect flush
    logic                       except;
    logic                       except_thread;

    // return stack side
    logic                       rs_except;
    logic                       rs_except_thread;
    logic                       rs_read_clkEn;
    logic                       rs_write_wen;
    logic                       rs_thread;
    logic [RS_DATA_W-1:0]       rs_write_data;
    logic [RS_LNK_W-1:0]        rs_write_lnk;
    logic                       rs_write_trace;
    logic [RS_DATA_W-1:0]       rs_read_data;

    // pop response and occupancy
    logic                       pop_rsp_vld;
    logic                       pop_rsp_thread;
    logic                       pop_rsp_empty;
    logic [RS_DATA_W-1:0]       pop_rsp_data;
    logic [1:0][DEPTH_W-1:0]    depth;

    modport master (
        output req_vld, req_pop, req_data, req_lnk, req_trace,
        input  req_rdy,
        output except, except_thread,
        input  rs_except, rs_except_thread, rs_read_clkEn, rs_write_wen,
        input  rs_thread, rs_write_data, rs_write_lnk, rs_write_trace,
        output rs_read_data,
        input  pop_rsp_vld, pop_rsp_thread, pop_rsp_empty, pop_rsp_data, depth
    );

    modport slave (
        input  req_vld, req_pop, req_data, req_lnk, req_trace,
        output req_rdy,
        input  except, except_thread,
        output rs_except, rs_except_thread, rs_read_clkEn, rs_write_wen,
        output rs_thread, rs_write_data, rs_write_lnk, rs_write_trace,
        input  rs_read_data,
        output pop_rsp_vld, pop_rsp_thread, pop_rsp_empty, pop_rsp_data, depth
    );

endinterface

// File: rtl/rs_req_fifo.sv
// Per-thread request queue of Q_DEPTH rs_req_t entries with synchronous flush.
// Head is visible combinationally; a write becomes visible the cycle after.
// full blocks writes; no full-with-read or empty-queue bypass; flush wins.
module rs_req_fifo
    import rs_ctrl_pkg::*;
#(
    parameter int Q_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    wr_en,
    input  rs_req_t wr_dat,
    input  logic    rd_en,
    output rs_req_t rd_dat,
    output logic    full,
    output logic    empty
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);

    rs_req_t            mem [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               wr_ok;
    logic               rd_ok;

    assign full   = (cnt == CNT_W'(Q_DEPTH));
    assign empty  = (cnt == '0);
    assign wr_ok  = wr_en && !full && !flush;
    assign rd_ok  = rd_en && !empty && !flush;
    assign rd_dat = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ret_stack_ctrl.sv
// Round-robin scheduler of per-thread push/pop requests onto the return stack.
// Issue >= 1 cycle after enqueue; pop response registered one cycle after issue.
// req_rdy drops when a thread queue is full or that thread is being flushed.
//
// Ports: clk/rst_n (async active-low); bus (slave) carries the per-thread
// requests and req_rdy, except/except_thread, the rs_* stack strobes and
// read data, the pop_rsp_* response and the per-thread depth counters.
module ret_stack_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int Q_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ret_stack_ctrl_if.slave bus
);
    rs_req_t [1:0]              q_in;
    rs_req_t [1:0]              q_head;
    logic [1:0]                 q_full;
    logic [1:0]                 q_empty;
    logic [1:0]                 q_wr;
    logic [1:0]                 q_rd;
    logic [1:0]                 q_flush;
    logic [1:0]                 rdy;

    logic                       gnt_vld;
    logic                       gnt_thr;
    logic                       last_gnt;
    rs_req_t                    head;
    logic                       head_live;
    logic                       rd_en;
    logic                       wen;

    logic [1:0][DEPTH_W-1:0]    depth_q;
    logic                       rsp_vld_q;
    logic                       rsp_thr_q;
    logic                       rsp_empty_q;
    logic [RS_DATA_W-1:0]       rsp_data_q;

    // The flushed thread neither enqueues nor keeps anything queued.
    always_comb begin
        q_flush = '0;
        if (bus.except) q_flush[bus.except_thread] = 1'b1;
    end

    assign rdy         = ~q_full & ~q_flush;
    assign bus.req_rdy = rdy;
    assign q_wr        = bus.req_vld & rdy;

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            q_in[t].pop   = bus.req_pop[t];
            q_in[t].data  = bus.req_data[t];
            q_in[t].lnk   = bus.req_lnk[t];
            q_in[t].trace = bus.req_trace[t];
        end
    end

    for (genvar t = 0; t < 2; t++) begin : g_q
        rs_req_fifo #(
            .Q_DEPTH (Q_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (q_flush[t]),
            .wr_en  (q_wr[t]),
            .wr_dat (q_in[t]),
            .rd_en  (q_rd[t]),
            .rd_dat (q_head[t]),
            .full   (q_full[t]),
            .empty  (q_empty[t])
        );
    end

    // Grant: lone candidate wins; on a tie the thread not granted last wins.
    // An exception cycle grants nothing so no strobe meets rs_except.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_thr = 1'b0;
        if (!bus.except) begin
            case (~q_empty)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_thr = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_thr = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_thr = ~last_gnt;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_thr = 1'b0;
                end
            endcase
        end
        head      = q_head[gnt_thr];
        head_live = (depth_q[gnt_thr] != '0);
        q_rd      = '0;
        if (gnt_vld) q_rd[gnt_thr] = 1'b1;
    end

    // A pop on an empty stack is dequeued without touching the stack.
    assign rd_en = gnt_vld && head.pop && head_live;
    assign wen   = gnt_vld && !head.pop;

    assign bus.rs_except        = bus.except;
    assign bus.rs_except_thread = bus.except_thread;
    assign bus.rs_read_clkEn    = rd_en;
    assign bus.rs_write_wen     = wen;
    assign bus.rs_thread        = gnt_thr;
    assign bus.rs_write_data    = wen ? head.data  : '0;
    assign bus.rs_write_lnk     = wen ? head.lnk   : '0;
    assign bus.rs_write_trace   = wen ? head.trace : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= 1'b1;
            depth_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_thr_q   <= 1'b0;
            rsp_empty_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (gnt_vld) last_gnt <= gnt_thr;

            // Push saturates: the stack itself wraps and drops its oldest entry.
            for (int t = 0; t < 2; t++) begin
                if (q_flush[t]) begin
                    depth_q[t] <= '0;
                end else if (gnt_vld && (gnt_thr == 1'(t))) begin
                    if (head.pop) begin
                        if (head_live) depth_q[t] <= depth_q[t] - DEPTH_W'(1);
                    end else if (depth_q[t] != DEPTH_W'(RS_DEPTH)) begin
                        depth_q[t] <= depth_q[t] + DEPTH_W'(1);
                    end
                end
            end

            rsp_vld_q   <= gnt_vld && head.pop;
            rsp_thr_q   <= gnt_thr;
            rsp_empty_q <= gnt_vld && head.pop && !head_live;
            rsp_data_q  <= rd_en ? bus.rs_read_data : '0;
        end
    end

    // A response for a thread flushed in the cycle it is presented is discarded.
    assign bus.pop_rsp_vld    = rsp_vld_q && !(bus.except && (bus.except_thread == rsp_thr_q));
    assign bus.pop_rsp_thread = rsp_thr_q;
    assign bus.pop_rsp_empty  = rsp_empty_q;
    assign bus.pop_rsp_data   = rsp_data_q;
    assign bus.depth          = depth_q;

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Directed bench for ret_stack_ctrl: a per-cycle vector table covering
// push/pop, empty pop, alternation and exception flush, then hand-written
// sequences for mid-operation reset and depth saturation.
module tb_ret_stack_ctrl;
    import rs_ctrl_pkg::*;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam int   NV = 22;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ret_stack_ctrl_if bus ();

    ret_stack_ctrl #(
        .Q_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  pop;
        logic [15:0] dat;
        logic        exc;
        logic        ext;
        logic [15:0] rdat;
        logic [1:0]  e_rdy;
        logic        e_rd;
        logic        e_wen;
        logic        e_thr;
        logic [15:0] e_wdat;
        logic        e_rvld;
        logic        e_rthr;
        logic        e_remp;
        logic [15:0] e_rdat;
        logic [4:0]  e_d0;
        logic [4:0]  e_d1;
        logic        e_exc;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [RS_DATA_W-1:0] act,
                       input logic [RS_DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] pop,
                         input logic [15:0] dat, input logic exc,
                         input logic ext, input logic [15:0] rdat);
        bus.req_vld       = vld;
        bus.req_pop       = pop;
        bus.req_data[0]   = RS_DATA_W'(dat);
        bus.req_data[1]   = RS_DATA_W'(dat);
        bus.req_lnk[0]    = 5'h08;
        bus.req_lnk[1]    = 5'h08;
        bus.req_trace     = 2'b00;
        bus.except        = exc;
        bus.except_thread = ext;
        bus.rs_read_data  = RS_DATA_W'(rdat);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rdy"},  RS_DATA_W'(bus.req_rdy), RS_DATA_W'(2'b11));
        chk({tag, " rd"},   RS_DATA_W'(bus.rs_read_clkEn), '0);
        chk({tag, " wen"},  RS_DATA_W'(bus.rs_write_wen), '0);
        chk({tag, " rvld"}, RS_DATA_W'(bus.pop_rsp_vld), '0);
        chk({tag, " d0"},   RS_DATA_W'(bus.depth[0]), '0);
        chk({tag, " d1"},   RS_DATA_W'(bus.depth[1]), '0);
    endtask

    initial begin
        int  nstrb;
        logic [4:0] exp_d;

        total = 0;
        bad   = 0;

        //   vld    pop    dat     exc ext rdat      rdy   rd wen thr wdat     rvld rthr remp rdat     d0    d1    exc
        tbl[0]  = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[1]  = '{2'b01,2'b00,16'h1234,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[2]  = '{2'b01,2'b01,16'h0000,N,N,16'h0000, 2'b11,N,Y,N,16'h1234, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[3]  = '{2'b00,2'b00,16'h0000,N,N,16'hABCD, 2'b11,Y,N,N,16'h0000, N,N,N,16'h0000, 5'd1,5'd0,N};
        tbl[4]  = '{2'b00,2'b00,16'h0000,N,N,16'hABCD, 2'b11,N,N,N,16'h0000, Y,N,N,16'hABCD, 5'd0,5'd0,N};
        tbl[5]  = '{2'b10,2'b10,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[6]  = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[7]  = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, Y,Y,Y,16'h0000, 5'd0,5'd0,N};
        tbl[8]  = '{2'b11,2'b00,16'h0001,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[9]  = '{2'b11,2'b00,16'h0002,N,N,16'h0000, 2'b11,N,Y,N,16'h0001, N,N,N,16'h0000, 5'd0,5'd0,N};
        tbl[10] = '{2'b11,2'b00,16'h0003,N,N,16'h0000, 2'b01,N,Y,Y,16'h0001, N,N,N,16'h0000, 5'd1,5'd0,N};
        tbl[11] = '{2'b11,2'b00,16'h0004,N,N,16'h0000, 2'b10,N,Y,N,16'h0002, N,N,N,16'h0000, 5'd1,5'd1,N};
        tbl[12] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b01,N,Y,Y,16'h0002, N,N,N,16'h0000, 5'd2,5'd1,N};
        tbl[13] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,Y,N,16'h0003, N,N,N,16'h0000, 5'd2,5'd2,N};
        tbl[14] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,Y,Y,16'h0004, N,N,N,16'h0000, 5'd3,5'd2,N};
        tbl[15] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd3,5'd3,N};
        tbl[16] = '{2'b11,2'b10,16'h0066,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd3,5'd3,N};
        tbl[17] = '{2'b11,2'b00,16'h0055,N,N,16'h0000, 2'b11,N,Y,N,16'h0066, N,N,N,16'h0000, 5'd3,5'd3,N};
        tbl[18] = '{2'b00,2'b00,16'h0000,N,N,16'h7777, 2'b01,Y,N,Y,16'h0000, N,N,N,16'h0000, 5'd4,5'd3,N};
        tbl[19] = '{2'b10,2'b00,16'h0099,Y,Y,16'h7777, 2'b01,N,N,N,16'h0000, N,N,N,16'h0000, 5'd4,5'd2,Y};
        tbl[20] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,Y,N,16'h0055, N,N,N,16'h0000, 5'd4,5'd0,N};
        tbl[21] = '{2'b00,2'b00,16'h0000,N,N,16'h0000, 2'b11,N,N,N,16'h0000, N,N,N,16'h0000, 5'd5,5'd0,N};

        // reset state
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 16'h0, N, N, 16'h0);
        #2;
        chk_idle("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // vector table: drive on negedge, compare just before posedge
        for (int i = 0; i < NV; i++) begin
            string tag;
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].pop, tbl[i].dat, tbl[i].exc, tbl[i].ext, tbl[i].rdat);
            #2;
            tag = $sformatf("c%0d", i);
            chk({tag, " rdy"},  RS_DATA_W'(bus.req_rdy), RS_DATA_W'(tbl[i].e_rdy));
            chk({tag, " rd"},   RS_DATA_W'(bus.rs_read_clkEn), RS_DATA_W'(tbl[i].e_rd));
            chk({tag, " wen"},  RS_DATA_W'(bus.rs_write_wen), RS_DATA_W'(tbl[i].e_wen));
            chk({tag, " exc"},  RS_DATA_W'(bus.rs_except), RS_DATA_W'(tbl[i].e_exc));
            if (tbl[i].e_rd || tbl[i].e_wen)
                chk({tag, " thr"}, RS_DATA_W'(bus.rs_thread), RS_DATA_W'(tbl[i].e_thr));
            if (tbl[i].e_wen) begin
                chk({tag, " wdat"}, bus.rs_write_data, RS_DATA_W'(tbl[i].e_wdat));
                chk({tag, " wlnk"}, RS_DATA_W'(bus.rs_write_lnk), RS_DATA_W'(5'h08));
            end
            chk({tag, " rvld"}, RS_DATA_W'(bus.pop_rsp_vld), RS_DATA_W'(tbl[i].e_rvld));
            if (tbl[i].e_rvld) begin
                chk({tag, " rthr"}, RS_DATA_W'(bus.pop_rsp_thread), RS_DATA_W'(tbl[i].e_rthr));
                chk({tag, " remp"}, RS_DATA_W'(bus.pop_rsp_empty), RS_DATA_W'(tbl[i].e_remp));
                chk({tag, " rdat"}, bus.pop_rsp_data, RS_DATA_W'(tbl[i].e_rdat));
            end
            chk({tag, " d0"}, RS_DATA_W'(bus.depth[0]), RS_DATA_W'(tbl[i].e_d0));
            chk({tag, " d1"}, RS_DATA_W'(bus.depth[1]), RS_DATA_W'(tbl[i].e_d1));
        end

        // reset mid-operation drops a queued push and clears depth
        @(negedge clk);
        drive(2'b10, 2'b00, 16'h00EE, N, N, 16'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 16'h0, N, N, 16'h0);
        rst_n = 1'b0;
        #2;
        chk_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk_idle("postrst");

        // 17 pushes on thread 0: every push strobes, depth stops at 16
        nstrb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive((c < 17) ? 2'b01 : 2'b00, 2'b00, 16'(c), N, N, 16'h0);
            #2;
            if (bus.rs_write_wen) begin
                exp_d = (nstrb > 16) ? 5'd16 : 5'(nstrb);
                chk($sformatf("sat%0d d0", nstrb), RS_DATA_W'(bus.depth[0]), RS_DATA_W'(exp_d));
                chk($sformatf("sat%0d wdat", nstrb), bus.rs_write_data, RS_DATA_W'(nstrb));
                nstrb++;
            end
        end
        chk("sat strobes", RS_DATA_W'(nstrb), RS_DATA_W'(17));
        chk("sat depth", RS_DATA_W'(bus.depth[0]), RS_DATA_W'(16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ret_stack_ctrl.md
# ret_stack_ctrl

Request scheduler in front of the frontend return stack: it accepts per-thread push (call) and pop (return) requests from branch prediction for two hardware threads. It buffers them in small per-thread queues and grants one stack operation per cycle with round-robin fairness. It tracks per-thread stack depth to suppress pops on an empty stack, and sequences exception flushes so that no stack operation collides with an exception cycle.

## Interface
Parameters:
- RS_DATA_W, 67, return-stack entry width
- RS_LNK_W, 5, link field width
- RS_DEPTH, 16, entries per thread
- Q_DEPTH, 2, request queue entries per thread

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  [1:0]  request valid, indexed by thread
- req_pop  in  [1:0]  1 = pop, 0 = push
- req_data  in  [1:0][RS_DATA_W-1:0]  push data
- req_lnk  in  [1:0][RS_LNK_W-1:0]  push link field
- req_trace  in  [1:0]  push trace flag
- req_rdy  out  [1:0]  queue not full
- except  in  1  exception/redirect flush
- except_thread  in  1  flushed thread
- rs_except, rs_except_thread  out  1, 1  to stack
- rs_read_clkEn  out  1  pop strobe
- rs_write_wen  out  1  push strobe
- rs_thread  out  1  thread of the strobe
- rs_write_data  out  RS_DATA_W  push data
- rs_write_lnk  out  RS_LNK_W  push link field
- rs_write_trace  out  1  push trace flag
- rs_read_data  in  RS_DATA_W  stack read data
- pop_rsp_vld  out  1  pop result valid
- pop_rsp_thread  out  1  thread of the pop result
- pop_rsp_empty  out  1  pop was on an empty stack; data is 0
- pop_rsp_data  out  RS_DATA_W  popped entry
- depth  out  [1:0][4:0]  per-thread occupancy, 0..16

## Operation
- Enqueue: when req_vld[t] and req_rdy[t], the request enters thread t's FIFO. req_rdy[t] = !full[t]. There is no full-with-dequeue bypass and no empty-queue bypass.
- Arbitration:
  - Candidates are the threads with a non-empty FIFO.
  - If exactly one thread is a candidate, it is granted.
  - If both are candidates, the thread that was not granted last is granted.
  - The last-grant register updates only on an actual grant.
- Issue of the granted FIFO head, in the same cycle as the grant:
  - Pop with depth[t] > 0: rs_read_clkEn = 1, rs_thread = t, depth[t] decrements.
  - Pop with depth[t] = 0: no stack strobe is issued. The pop is dequeued and marked empty.
  - Push: rs_write_wen = 1, rs_thread = t, rs_write_* driven from the head. depth[t] increments, saturating at 16. The stack wraps internally and the oldest entry is lost.
- rs_read_clkEn and rs_write_wen are never both high.
- Pop response is registered. In the cycle after a pop dequeue:
  - pop_rsp_vld = 1 and pop_rsp_thread = t.
  - pop_rsp_data = rs_read_data, or 0 with pop_rsp_empty = 1 if the pop was empty.
- Exception, for the cycle in which except = 1:
  - rs_except = except and rs_except_thread = except_thread, combinational pass-through.
  - No grant is made for either thread, no strobe is issued, and the last-grant register holds.
  - The except_thread FIFO is cleared, depth[except_thread] is set to 0, and req_rdy[except_thread] = 0, so no enqueue occurs that cycle.
  - The other thread may still enqueue.
  - If a pop response for except_thread is due in the next cycle, it is dropped (pop_rsp_vld = 0). A response for the other thread is still delivered.
- Reset (asynchronous, rst_n = 0):
  - FIFOs empty, depth = 0, last grant = thread 1, so thread 0 wins the first tie.
  - pop_rsp_* = 0.
  - All rs_* strobes are 0, because they are derived from the empty FIFOs.
  - req_rdy = 2'b11.
  - Reset asserted mid-operation discards all pending requests and any in-flight response.

## Timing
- A request accepted in cycle N is issued no earlier than N+1. Its pop response arrives at N+2.
- Throughput: one stack operation per cycle in total across both threads.
- depth updates are visible in the cycle after the issue.
- except has priority over every other event in the same cycle.

## Structure
- Package rs_ctrl_pkg holds:
  - constants RS_DATA_W, RS_LNK_W, RS_DEPTH
  - typedef rs_req_t {pop, data, lnk, trace}
- Sub-module rs_req_fifo: a Q_DEPTH-entry FIFO of rs_req_t with a synchronous flush input. It is instantiated once per thread.
- Arbiter, depth counters and the response register live in the top module.

## Test plan
- Reset, then idle → depth = {0,0}, req_rdy = 2'b11, rs_read_clkEn = rs_write_wen = 0, pop_rsp_vld = 0.
- Thread 0: push data 0x1234, lnk 5'h08, then pop → push strobe at N+1 with rs_thread = 0, then pop strobe. pop_rsp_data equals rs_read_data one cycle after the pop strobe. depth[0] goes 0→1→0.
- Thread 1: pop on an empty stack → no rs_read_clkEn. Two cycles after acceptance: pop_rsp_vld = 1, pop_rsp_empty = 1, pop_rsp_data = 0, pop_rsp_thread = 1.
- Both threads hold req_vld continuously with pushes → strobes alternate thread 0,1,0,1. req_rdy never drops below one free entry per cycle of drain.
- 17 pushes on thread 0 → depth[0] saturates at 16, while 17 write strobes are still issued.
- Thread 1 has 2 queued requests and a pop response due, then except = 1 with except_thread = 1 → rs_except = 1 and no strobe that cycle. Thread 1 FIFO is empty, depth[1] = 0, and the response is dropped. Thread 0 issues the next cycle.
